// File: rtl/uart_result_tx.sv
// 8N1 UART transmitter for a p_N-bit result word, sent LSB byte first.
// The next-state logic computes every register's next value, so all outputs leave the design straight from flops.
module uart_result_tx #(
    parameter int unsigned clk_freq       = 50000000,
    parameter int unsigned uart_baud_rate = 57600,
    parameter int unsigned p_N            = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [p_N-1:0] i_data,
    input  logic           i_start,
    output logic           o_busy,
    output logic           uart_txd,
    output logic           o_done
);

    localparam int unsigned DIV = clk_freq / uart_baud_rate;
    localparam int unsigned NB  = (p_N + 7) / 8;
    localparam int unsigned SW  = 8 * NB;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_result_tx: clk_freq / uart_baud_rate must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] shreg, shreg_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [BW-1:0] byte_cnt, byte_n;
    logic          txd_n, busy_n, done_n;
    logic          baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            uart_txd <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            uart_txd <= txd_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        txd_n   = uart_txd;
        busy_n  = o_busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                txd_n  = 1'b1;
                busy_n = 1'b0;
                if (i_start) begin
                    state_n = START;
                    shreg_n = SW'(i_data);
                    baud_n  = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                    txd_n   = shreg[0];
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shreg_n = shreg >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_n   = '0;
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        // shreg[1] is the bit that lands in bit 0 at this same edge
                        txd_n = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (byte_cnt != BYTE_LAST) begin
                        byte_n  = byte_cnt + 1'b1;
                        state_n = START;
                        txd_n   = 1'b0;
                    end else begin
                        byte_n  = '0;
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx at DIV=4: a line monitor decodes bytes against a scoreboard queue,
// and per-cycle captures check framing, busy/done timing, reset behaviour and padding.
module tb_uart_result_tx;

    localparam int DIV = 4;
    localparam int FRAME = 2 * 10 * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] i_data;
    logic        start16, start12;
    logic        busy16, txd16, done16;
    logic        busy12, txd12, done12;

    uart_result_tx #(.clk_freq(1000), .uart_baud_rate(250), .p_N(16)) dut16 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_start(start16),
        .o_busy(busy16), .uart_txd(txd16), .o_done(done16)
    );

    uart_result_tx #(.clk_freq(1000), .uart_baud_rate(250), .p_N(12)) dut12 (
        .clk(clk), .rst(rst), .i_data(i_data[11:0]), .i_start(start12),
        .o_busy(busy12), .uart_txd(txd12), .o_done(done12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard of expected bytes on dut16's line, in transmission order.
    logic [7:0] sb[$];

    int         mon_cnt = -1;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (rst) begin
            mon_cnt = -1;
        end else if (mon_cnt < 0) begin
            if (txd16 === 1'b0) mon_cnt = 0;
        end else begin
            mon_cnt++;
            if (mon_cnt == DIV / 2) begin
                chk("mon_start_bit", 32'(txd16), 32'd0);
            end else if (mon_cnt > DIV && mon_cnt < 9 * DIV && (mon_cnt % DIV) == DIV / 2) begin
                mon_byte[mon_cnt / DIV - 1] = txd16;
            end else if (mon_cnt == 9 * DIV + DIV / 2) begin
                chk("mon_stop_bit", 32'(txd16), 32'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_byte: got %h, expected no byte", mon_byte);
                end else begin
                    chk("sb_byte", 32'(mon_byte), 32'(sb.pop_front()));
                end
            end
            if (mon_cnt == 10 * DIV - 1) mon_cnt = -1;
        end
    end

    logic cap_txd [0:399];
    logic cap_busy[0:399];
    logic cap_done[0:399];

    // Records n cycles; i_start of the selected DUT is high for cycles [from, to) with data wd.
    task automatic capture(input int sel, input int n, input int from, input int to,
                           input logic [15:0] wd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_txd[i]  = sel ? txd12  : txd16;
            cap_busy[i] = sel ? busy12 : busy16;
            cap_done[i] = sel ? done12 : done16;
            if (i >= from && i < to) begin
                i_data = wd;
                if (sel) start12 = 1'b1; else start16 = 1'b1;
            end else begin
                if (sel) start12 = 1'b0; else start16 = 1'b0;
            end
        end
    endtask

    task automatic pulse(input int sel, input logic [15:0] d);
        @(posedge clk);
        #1;
        i_data = d;
        if (sel) start12 = 1'b1; else start16 = 1'b1;
        @(posedge clk);
        #1;
        start12 = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic check_line(input string name, input logic [19:0] line_in);
        logic [0:19] line;
        line = line_in;
        for (int j = 0; j < 20; j++) begin
            chk(name, 32'({cap_txd[4*j], cap_txd[4*j+1], cap_txd[4*j+2], cap_txd[4*j+3]}),
                32'({4{line[j]}}));
        end
    endtask

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_busy[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic wait_done16(input string name);
        int t = 0;
        while (done16 !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(done16), 32'd1);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[6];

    localparam logic [19:0] A55A_LINE = 20'b0010110101_0101001011;
    localparam logic [19:0] FFF_LINE  = 20'b0111111111_0111100001;

    initial begin
        vecs[0] = '{16'h0000, 8'h00, 8'h00};
        vecs[1] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[2] = '{16'h0001, 8'h01, 8'h00};
        vecs[3] = '{16'h8000, 8'h00, 8'h80};
        vecs[4] = '{16'h1234, 8'h34, 8'h12};
        vecs[5] = '{16'hC3A5, 8'hA5, 8'hC3};

        // Reset held with start asserted
        rst = 1'b1;
        start16 = 1'b1;
        start12 = 1'b0;
        i_data = 16'hA55A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_txd", 32'(txd16), 32'd1);
            chk("rst_busy", 32'(busy16), 32'd0);
            chk("rst_done", 32'(done16), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(8'h5A);
        sb.push_back(8'hA5);
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(negedge clk);
        chk("start_after_rst_busy", 32'(busy16), 32'd1);
        chk("start_after_rst_txd", 32'(txd16), 32'd0);
        wait_done16("first_frame_done_timeout");

        // Basic frame
        sb.push_back(8'h5A);
        sb.push_back(8'hA5);
        pulse(0, 16'hA55A);
        capture(0, 82, -1, -1, 16'h0);
        check_line("basic_line", A55A_LINE);
        chk("basic_busy_len", 32'(count_busy(82)), 32'(FRAME));
        chk("basic_done_count", 32'(count_done(82)), 32'd1);
        chk("basic_done_pos", 32'(cap_done[FRAME]), 32'd1);
        chk("basic_idle_txd", 32'(cap_txd[FRAME]), 32'd1);

        // Start during DATA is ignored
        sb.push_back(8'h5A);
        sb.push_back(8'hA5);
        pulse(0, 16'hA55A);
        capture(0, 82, 30, 31, 16'h1234);
        check_line("ignored_line", A55A_LINE);
        chk("ignored_done_count", 32'(count_done(82)), 32'd1);
        capture(0, 60, -1, -1, 16'h0);
        chk("ignored_no_second_frame", 32'(count_busy(60)), 32'd0);

        // Start held high: back-to-back frames
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        @(posedge clk);
        #1;
        i_data = 16'h00FF;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        capture(0, 170, 0, 150, 16'h00FF);
        chk("held_done_80", 32'(cap_done[80]), 32'd1);
        chk("held_done_161", 32'(cap_done[161]), 32'd1);
        chk("held_done_count", 32'(count_done(170)), 32'd2);
        chk("held_stop_len", 32'({cap_txd[75], cap_txd[76], cap_txd[77], cap_txd[78],
                                  cap_txd[79], cap_txd[80], cap_txd[81]}), 32'b0111110);
        chk("held_busy_gap", 32'({cap_busy[79], cap_busy[80], cap_busy[81]}), 32'b101);

        // Reset during data bit 3 of byte 0
        sb.push_back(8'h5A);
        sb.push_back(8'hA5);
        pulse(0, 16'hA55A);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", 32'(txd16), 32'd1);
        chk("midrst_busy", 32'(busy16), 32'd0);
        chk("midrst_done", 32'(done16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        capture(0, 20, -1, -1, 16'h0);
        chk("midrst_no_done", 32'(count_done(20)), 32'd0);
        sb.push_back(8'h5A);
        sb.push_back(8'hA5);
        pulse(0, 16'hA55A);
        capture(0, 82, -1, -1, 16'h0);
        check_line("after_rst_line", A55A_LINE);
        chk("after_rst_done_pos", 32'(cap_done[FRAME]), 32'd1);

        // Padding above p_N=12
        pulse(1, 16'h0FFF);
        capture(1, 82, -1, -1, 16'h0);
        check_line("pad_line", FFF_LINE);
        chk("pad_busy_len", 32'(count_busy(82)), 32'(FRAME));

        // Table of words
        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].b0);
            sb.push_back(vecs[v].b1);
            pulse(0, vecs[v].data);
            capture(0, 82, -1, -1, 16'h0);
            chk("vec_busy_len", 32'(count_busy(82)), 32'(FRAME));
            chk("vec_done_pos", 32'(cap_done[FRAME]), 32'd1);
            chk("vec_done_count", 32'(count_done(82)), 32'd1);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
